s2p_deserializer: RTL and testbench

S2P_DESERIALIZER -- requirements
Module: s2p_deserializer

---
 rtl/s2p_pkg.sv | 17 +
 rtl/s2p_if.sv | 30 +++
 rtl/s2p_out_reg.sv | 38 +++
 rtl/s2p_deserializer.sv | 131 +++++++++++++
 tb/tb_s2p_deserializer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } s2p_state_e;

  function automatic int beats_f(input int data_w, input int lanes);
    return data_w / lanes;
  endfunction

  function automatic int cnt_w_f(input int data_w, input int lanes);
    return $clog2((data_w / lanes) + 1);
  endfunction

endpackage

// File: rtl/s2p_if.sv
// Serial-in / parallel-out handshake bundle; slave is the deserializer's view.
interface s2p_if
  import s2p_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
) ();

  localparam int CNT_W = cnt_w_f(DATA_W, LANES);

  logic [LANES-1:0]  din_serial;
  logic              din_valid;
  logic              din_ready;
  logic              flush;
  logic [DATA_W-1:0] dout_parallel;
  logic              dout_valid;
  logic              dout_ready;
  logic [CNT_W-1:0]  beat_cnt;

  modport slave (
    input  din_serial, din_valid, flush, dout_ready,
    output din_ready, dout_parallel, dout_valid, beat_cnt
  );

  modport master (
    output din_serial, din_valid, flush, dout_ready,
    input  din_ready, dout_parallel, dout_valid, beat_cnt
  );

endinterface

// File: rtl/s2p_out_reg.sv
// Output word register with valid/ready handshake; o_can_load says a load this
// cycle will not overwrite an unconsumed word.
module s2p_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_can_load
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_can_load = !r_valid || i_ready;

  // Load wins over drain so a consumed word is replaced without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/s2p_deserializer.sv
// Collects LANES-wide beats into DATA_W-bit words; a full word waits in the
// collector (PENDING) while the output register is still occupied.
module s2p_deserializer
  import s2p_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1
) (
  input logic  clk,
  input logic  rst,
  s2p_if.slave bus
);

  localparam int BEATS = beats_f(DATA_W, LANES);
  localparam int CNT_W = cnt_w_f(DATA_W, LANES);

  s2p_state_e        r_state;
  logic [DATA_W-1:0] r_col;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_din_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_can_load;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_shift;

  assign w_din_ready   = (r_state == COLLECT) && !rst;
  assign w_accept      = bus.din_valid && w_din_ready && !bus.flush;
  assign w_last        = (r_cnt == CNT_W'(BEATS - 1));
  assign bus.din_ready = w_din_ready;
  assign bus.beat_cnt  = r_cnt;

  always_comb begin
    w_shift = '0;
    if (MSB_FIRST != 0) begin
      w_shift = {r_col[DATA_W-LANES-1:0], bus.din_serial};
    end else begin
      w_shift = {bus.din_serial, r_col[DATA_W-1:LANES]};
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_data = '0;
    case (r_state)
      COLLECT: begin
        if (w_accept && w_last && w_can_load) begin
          w_load      = 1'b1;
          w_load_data = w_shift;
        end else begin
          w_load      = 1'b0;
          w_load_data = '0;
        end
      end
      PENDING: begin
        if (bus.dout_ready) begin
          w_load      = 1'b1;
          w_load_data = r_col;
        end else begin
          w_load      = 1'b0;
          w_load_data = '0;
        end
      end
      default: begin
        w_load      = 1'b0;
        w_load_data = '0;
      end
    endcase
  end

  // Collector cleared after every hand-off so unwritten bits always read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.flush) begin
            r_cnt <= '0;
            r_col <= '0;
          end else if (w_accept && w_last && w_can_load) begin
            r_cnt <= '0;
            r_col <= '0;
          end else if (w_accept && w_last) begin
            r_state <= PENDING;
            r_cnt   <= CNT_W'(BEATS);
            r_col   <= w_shift;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_col <= w_shift;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        PENDING: begin
          if (bus.dout_ready) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_col   <= '0;
          end else begin
            r_state <= PENDING;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_cnt   <= '0;
          r_col   <= '0;
        end
      endcase
    end
  end

  s2p_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_ready    (bus.dout_ready),
    .o_data     (bus.dout_parallel),
    .o_valid    (bus.dout_valid),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_s2p_deserializer.sv
// Directed bench: two 8x1 instances (MSB/LSB first) share stimulus, plus a 16x4 one.
module tb_s2p_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       din8 = 1'b0, dv8 = 1'b0, fl8 = 1'b0, dr8 = 1'b1;
  logic [3:0] din16 = 4'h0;
  logic       dv16 = 1'b0, fl16 = 1'b0, dr16 = 1'b1;

  s2p_if #(.DATA_W(8),  .LANES(1)) if8m ();
  s2p_if #(.DATA_W(8),  .LANES(1)) if8l ();
  s2p_if #(.DATA_W(16), .LANES(4)) if16 ();

  assign if8m.din_serial = din8;  assign if8m.din_valid = dv8;
  assign if8m.flush      = fl8;   assign if8m.dout_ready = dr8;
  assign if8l.din_serial = din8;  assign if8l.din_valid = dv8;
  assign if8l.flush      = fl8;   assign if8l.dout_ready = dr8;
  assign if16.din_serial = din16; assign if16.din_valid = dv16;
  assign if16.flush      = fl16;  assign if16.dout_ready = dr16;

  s2p_deserializer #(.DATA_W(8), .LANES(1), .MSB_FIRST(1)) u8m (.clk(clk), .rst(rst), .bus(if8m));
  s2p_deserializer #(.DATA_W(8), .LANES(1), .MSB_FIRST(0)) u8l (.clk(clk), .rst(rst), .bus(if8l));
  s2p_deserializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1)) u16 (.clk(clk), .rst(rst), .bus(if16));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // bits[7] is the first beat sent
  task automatic feed8(input logic [7:0] bits, input string tag);
    for (int i = 7; i >= 0; i--) begin
      din8 = bits[i];
      dv8  = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_cnt_m"}, 32'(if8m.beat_cnt), 32'((8 - i) % 8));
      chk({tag, "_cnt_l"}, 32'(if8l.beat_cnt), 32'((8 - i) % 8));
    end
    dv8 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs [4];
  logic       stable;
  logic [15:0] two_words;

  initial begin
    vecs[0] = '{bits: 8'hF0, exp_msb: 8'hF0, exp_lsb: 8'h0F};
    vecs[1] = '{bits: 8'hC3, exp_msb: 8'hC3, exp_lsb: 8'hC3};
    vecs[2] = '{bits: 8'h96, exp_msb: 8'h96, exp_lsb: 8'h69};
    vecs[3] = '{bits: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};

    // reset state
    #2;
    chk("rst_dout",  32'(if8m.dout_parallel), 32'h0);
    chk("rst_valid", 32'(if8m.dout_valid),    32'h0);
    chk("rst_cnt",   32'(if8m.beat_cnt),      32'h0);
    chk("rst_rdy",   32'(if8m.din_ready),     32'h0);
    chk("rst_rdy16", 32'(if16.din_ready),     32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_rdy",   32'(if8m.din_ready), 32'h1);
    chk("rel_rdy16", 32'(if16.din_ready), 32'h1);

    // table-driven words, dout_ready held high
    for (int v = 0; v < 4; v++) begin
      feed8(vecs[v].bits, "tbl");
      chk("tbl_valid_m", 32'(if8m.dout_valid),    32'h1);
      chk("tbl_data_m",  32'(if8m.dout_parallel), 32'(vecs[v].exp_msb));
      chk("tbl_valid_l", 32'(if8l.dout_valid),    32'h1);
      chk("tbl_data_l",  32'(if8l.dout_parallel), 32'(vecs[v].exp_lsb));
      @(posedge clk); #1;
      chk("tbl_fall_m", 32'(if8m.dout_valid), 32'h0);
      chk("tbl_fall_l", 32'(if8l.dout_valid), 32'h0);
    end

    // back-to-back with no gap
    feed8(8'hF0, "b2b1");
    chk("b2b1_data", 32'(if8m.dout_parallel), 32'hF0);
    feed8(8'hC3, "b2b2");
    chk("b2b2_data", 32'(if8m.dout_parallel), 32'hC3);
    chk("b2b2_vld",  32'(if8m.dout_valid),    32'h1);
    @(posedge clk); #1;

    // 16-bit, 4 lanes
    for (int b = 0; b < 4; b++) begin
      din16 = 4'(4'hA + b);
      dv16  = 1'b1;
      @(posedge clk); #1;
      chk("w16_cnt", 32'(if16.beat_cnt), 32'((b + 1) % 4));
    end
    dv16 = 1'b0;
    chk("w16_valid", 32'(if16.dout_valid),    32'h1);
    chk("w16_data",  32'(if16.dout_parallel), 32'hABCD);
    @(posedge clk); #1;
    chk("w16_fall",  32'(if16.dout_valid), 32'h0);

    // stall: 0x5A then 0x3C with dout_ready low for 20 cycles, flush while PENDING
    dr8 = 1'b0;
    two_words = 16'h5A3C;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      din8 = (c < 16) ? two_words[15 - c] : 1'b1;
      dv8  = 1'b1;
      fl8  = (c >= 18);
      @(posedge clk); #1;
      if (c >= 7 && (if8m.dout_parallel !== 8'h5A || if8m.dout_valid !== 1'b1)) stable = 1'b0;
    end
    chk("stall_stable",  32'(stable),              32'h1);
    chk("stall_rdy",     32'(if8m.din_ready),      32'h0);
    chk("stall_cnt_m",   32'(if8m.beat_cnt),       32'h8);
    chk("stall_cnt_l",   32'(if8l.beat_cnt),       32'h8);
    chk("stall_data_l",  32'(if8l.dout_parallel),  32'h5A);
    dv8 = 1'b0; fl8 = 1'b0; dr8 = 1'b1;
    @(posedge clk); #1;
    chk("rel_data_m",  32'(if8m.dout_parallel), 32'h3C);
    chk("rel_data_l",  32'(if8l.dout_parallel), 32'h3C);
    chk("rel_valid",   32'(if8m.dout_valid),    32'h1);
    chk("rel_din_rdy", 32'(if8m.din_ready),     32'h1);
    chk("rel_cnt",     32'(if8m.beat_cnt),      32'h0);
    @(posedge clk); #1;
    chk("rel_fall",    32'(if8m.dout_valid),    32'h0);

    // flush after 3 beats; beat offered with flush is ignored
    for (int i = 0; i < 3; i++) begin
      din8 = 1'b1; dv8 = 1'b1;
      @(posedge clk); #1;
    end
    chk("fl_cnt3", 32'(if8m.beat_cnt), 32'h3);
    fl8 = 1'b1;
    @(posedge clk); #1;
    fl8 = 1'b0;
    chk("fl_cnt0", 32'(if8m.beat_cnt), 32'h0);
    chk("fl_vld",  32'(if8m.dout_valid), 32'h0);
    feed8(8'hAA, "fl");
    chk("fl_data_m", 32'(if8m.dout_parallel), 32'hAA);
    chk("fl_data_l", 32'(if8l.dout_parallel), 32'h55);
    chk("fl_valid",  32'(if8m.dout_valid),    32'h1);
    @(posedge clk); #1;

    // async reset mid-word with a word held in the output register
    dr8 = 1'b0;
    feed8(8'h96, "pre");
    chk("pre_data", 32'(if8m.dout_parallel), 32'h96);
    for (int i = 0; i < 5; i++) begin
      din8 = 1'b1; dv8 = 1'b1;
      @(posedge clk); #1;
    end
    dv8 = 1'b0;
    chk("pre_cnt", 32'(if8m.beat_cnt), 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  32'(if8m.dout_parallel), 32'h0);
    chk("arst_valid", 32'(if8m.dout_valid),    32'h0);
    chk("arst_cnt",   32'(if8m.beat_cnt),      32'h0);
    chk("arst_rdy",   32'(if8m.din_ready),     32'h0);
    chk("arst_data_l", 32'(if8l.dout_parallel), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dr8 = 1'b1;
    #1;
    chk("post_rdy", 32'(if8m.din_ready), 32'h1);
    feed8(8'h01, "post");
    chk("post_data_m", 32'(if8m.dout_parallel), 32'h01);
    chk("post_data_l", 32'(if8l.dout_parallel), 32'h80);
    chk("post_valid",  32'(if8m.dout_valid),    32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
